// File: rtl/multiport_regfile.sv
// multiport_regfile
//   Multi-read, multi-write register file with byte enables. The write ports
//   are ordered by program order, and the higher index is the younger write.
//   Entry 0 can be hardwired to zero. Same-cycle write-to-read forwarding is
//   optional. A self-timed CLEAR sequence zeroes the array one entry per cycle
//   after reset and after each clear request.
//
// Ports
//   clk          single clock; all state updates on its rising edge
//   rst          asynchronous, active-high reset (restarts the CLEAR sequence)
//   raddr[r]     read address of read port r
//   rdata[r]     combinational read data of read port r
//   we[p]        byte write enables of write port p
//   waddr[p]     write address of write port p
//   wdata[p]     write data of write port p
//   clear_req    request to zero all entries (sampled in IDLE only)
//   ready        registered, high while in IDLE
//   wr_conflict  two write ports enable the same byte of the same entry
//
// State  | meaning
// -------+--------------------------------------------------------------
// CLEAR  | zeroing entry clr_ptr each cycle; writes dropped, reads give 0
// IDLE   | normal operation; writes commit, reads return data

module multiport_regfile #(
  parameter int NREAD    = 4,
  parameter int NWRITE   = 2,
  parameter int DEPTH    = 64,
  parameter int WIDTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH),
  localparam int BW      = WIDTH / 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREAD-1:0][AW-1:0]      raddr,
  output logic [NREAD-1:0][WIDTH-1:0]   rdata,
  input  logic [NWRITE-1:0][BW-1:0]     we,
  input  logic [NWRITE-1:0][AW-1:0]     waddr,
  input  logic [NWRITE-1:0][WIDTH-1:0]  wdata,
  input  logic                          clear_req,
  output logic                          ready,
  output logic                          wr_conflict
);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_ENTRY = AW'(DEPTH - 1);
  localparam bit            ZR         = (ZERO_REG != 0);
  localparam bit            BYP        = (BYPASS != 0);

  state_t          state;
  logic [AW-1:0]   clr_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  // A write port is live when it targets a real (non-hardwired) entry.
  logic [NWRITE-1:0] wport_live;

  always_comb begin
    wport_live = '0;
    for (int p = 0; p < NWRITE; p++) begin
      wport_live[p] = !(ZR && (waddr[p] == '0));
    end
  end

  // Control FSM: the clear pointer walks every entry once, and the edge that
  // clears the last entry also raises ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_CLEAR;
      clr_ptr <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          clr_ptr <= clr_ptr + AW'(1);
          if (clr_ptr == LAST_ENTRY) begin
            state <= S_IDLE;
            ready <= 1'b1;
          end
        end
        S_IDLE: begin
          if (clear_req) begin
            state   <= S_CLEAR;
            clr_ptr <= '0;
            ready   <= 1'b0;
          end
        end
        default: begin
          state   <= S_CLEAR;
          clr_ptr <= '0;
          ready   <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset of its own; the CLEAR walk zeroes it. Ports are
  // visited in ascending order, so the youngest enabled byte lands last.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      mem[clr_ptr] <= '0;
    end else begin
      for (int p = 0; p < NWRITE; p++) begin
        for (int b = 0; b < BW; b++) begin
          if (we[p][b] && wport_live[p]) begin
            mem[waddr[p]][8*b +: 8] <= wdata[p][8*b +: 8];
          end
        end
      end
    end
  end

  // Read path. While rst is high the state is already CLEAR, so the outputs
  // stay at zero without a separate reset term.
  always_comb begin
    rdata = '0;
    if (state == S_IDLE) begin
      for (int r = 0; r < NREAD; r++) begin
        if (!(ZR && (raddr[r] == '0))) begin
          rdata[r] = mem[raddr[r]];
          if (BYP) begin
            for (int p = 0; p < NWRITE; p++) begin
              for (int b = 0; b < BW; b++) begin
                if (we[p][b] && (waddr[p] == raddr[r])) begin
                  rdata[r][8*b +: 8] = wdata[p][8*b +: 8];
                end
              end
            end
          end
        end
      end
    end
  end

  // Pairwise overlap check. Writes discarded by the zero register are excluded.
  always_comb begin
    wr_conflict = 1'b0;
    if (state == S_IDLE) begin
      for (int p = 0; p < NWRITE; p++) begin
        for (int q = p + 1; q < NWRITE; q++) begin
          if (wport_live[p] && wport_live[q] && (waddr[p] == waddr[q]) &&
              ((we[p] & we[q]) != '0)) begin
            wr_conflict = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_multiport_regfile.sv
module tb_multiport_regfile;
  localparam int NR = 4;
  localparam int NW = 2;
  localparam int D  = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR-1:0][5:0]  raddr = '0;
  logic [NR-1:0][31:0] rdata, rdata_nb;
  logic [NW-1:0][3:0]  we = '0;
  logic [NW-1:0][5:0]  waddr = '0;
  logic [NW-1:0][31:0] wdata = '0;
  logic clear_req = 1'b0;
  logic ready, ready_nb, wr_conflict, wr_conflict_nb;

  always #5 clk = ~clk;

  multiport_regfile dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .we(we),
    .waddr(waddr), .wdata(wdata), .clear_req(clear_req), .ready(ready),
    .wr_conflict(wr_conflict)
  );

  multiport_regfile #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_nb), .we(we),
    .waddr(waddr), .wdata(wdata), .clear_req(clear_req), .ready(ready_nb),
    .wr_conflict(wr_conflict_nb)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Observable behaviour only: contents, "clearing" flag and edges left
  // until ready. A clear makes every entry read as zero afterwards, so the
  // model zeroes the whole array at the moment the clear starts.
  logic [31:0] m_mem [D];
  bit          m_ready;
  int          m_left;

  function automatic void m_reset();
    foreach (m_mem[i]) m_mem[i] = '0;
    m_ready = 1'b0;
    m_left  = D;
  endfunction

  function automatic logic [31:0] m_rd(input logic [5:0] a, input bit byp);
    logic [31:0] v;
    if (rst || !m_ready || a == 6'd0) return 32'h0;
    v = m_mem[a];
    if (byp) begin
      for (int b = 0; b < 4; b++) begin
        for (int p = NW - 1; p >= 0; p--) begin
          if (we[p][b] && waddr[p] == a) begin
            v[8*b +: 8] = wdata[p][8*b +: 8];
            break;
          end
        end
      end
    end
    return v;
  endfunction

  function automatic logic m_conf();
    int cnt [D][4];
    if (rst || !m_ready) return 1'b0;
    foreach (cnt[i, j]) cnt[i][j] = 0;
    for (int p = 0; p < NW; p++)
      for (int b = 0; b < 4; b++)
        if (we[p][b] && waddr[p] != 6'd0) cnt[waddr[p]][b]++;
    foreach (cnt[i, j]) if (cnt[i][j] > 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_tick();
    if (rst) begin
      m_reset();
    end else if (!m_ready) begin
      m_left--;
      if (m_left == 0) m_ready = 1'b1;
    end else begin
      for (int p = 0; p < NW; p++)
        for (int b = 0; b < 4; b++)
          if (we[p][b] && waddr[p] != 6'd0) m_mem[waddr[p]][8*b +: 8] = wdata[p][8*b +: 8];
      if (clear_req) begin
        foreach (m_mem[i]) m_mem[i] = '0;
        m_ready = 1'b0;
        m_left  = D;
      end
    end
  endfunction

  // ---------------- cycle helpers ----------------
  task automatic settle();
    #4;
  endtask

  task automatic check_all();
    chk("ready", {31'b0, ready}, {31'b0, m_ready});
    chk("ready_nb", {31'b0, ready_nb}, {31'b0, m_ready});
    chk("wr_conflict", {31'b0, wr_conflict}, {31'b0, m_conf()});
    chk("wr_conflict_nb", {31'b0, wr_conflict_nb}, {31'b0, m_conf()});
    for (int r = 0; r < NR; r++) begin
      chk($sformatf("rdata[%0d]", r), rdata[r], m_rd(raddr[r], 1'b1));
      chk($sformatf("rdata_nb[%0d]", r), rdata_nb[r], m_rd(raddr[r], 1'b0));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_tick();
    #1;
  endtask

  task automatic step();
    settle();
    check_all();
    tick();
  endtask

  task automatic idle_inputs();
    we = '0; waddr = '0; wdata = '0; clear_req = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  we0;
    logic [5:0]  wa0;
    logic [31:0] wd0;
    logic [3:0]  we1;
    logic [5:0]  wa1;
    logic [31:0] wd1;
    logic [5:0]  ra;
    logic [31:0] exp_byp;
    logic [31:0] exp_nb;
    logic        exp_conf;
  } vec_t;

  vec_t vt [9];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{4'hF, 6'd5, 32'hDEADBEEF, 4'h0, 6'd0, 32'h0,        6'd5, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vt[1] = '{4'h5, 6'd5, 32'h11223344, 4'h0, 6'd0, 32'h0,        6'd5, 32'hDE22BE44, 32'hDEADBEEF, 1'b0};
    vt[2] = '{4'h0, 6'd0, 32'h0,        4'h0, 6'd0, 32'h0,        6'd5, 32'hDE22BE44, 32'hDE22BE44, 1'b0};
    vt[3] = '{4'hF, 6'd7, 32'hAAAAAAAA, 4'h3, 6'd7, 32'h5555FFFF, 6'd7, 32'hAAAAFFFF, 32'h00000000, 1'b1};
    vt[4] = '{4'h0, 6'd0, 32'h0,        4'h0, 6'd0, 32'h0,        6'd7, 32'hAAAAFFFF, 32'hAAAAFFFF, 1'b0};
    vt[5] = '{4'h0, 6'd0, 32'h0,        4'hF, 6'd9, 32'h12345678, 6'd9, 32'h12345678, 32'h00000000, 1'b0};
    vt[6] = '{4'h0, 6'd0, 32'h0,        4'h0, 6'd0, 32'h0,        6'd9, 32'h12345678, 32'h12345678, 1'b0};
    vt[7] = '{4'hF, 6'd0, 32'hFFFFFFFF, 4'hF, 6'd0, 32'hFFFFFFFF, 6'd0, 32'h00000000, 32'h00000000, 1'b0};
    vt[8] = '{4'h0, 6'd0, 32'h0,        4'h0, 6'd0, 32'h0,        6'd0, 32'h00000000, 32'h00000000, 1'b0};

    m_reset();

    // Reset held: outputs quiet even with writes and clear requests applied.
    we = '{4'hF, 4'hF}; waddr = '{6'd3, 6'd3}; wdata = '{32'h1, 32'h2};
    raddr = '{6'd3, 6'd2, 6'd1, 6'd0}; clear_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("rst_rdata", rdata[3], 32'h0);
      chk("rst_conflict", {31'b0, wr_conflict}, 32'h0);
      check_all();
      tick();
    end
    idle_inputs();
    rst = 1'b0;

    // Reset release: ready low for exactly D edges.
    for (int i = 0; i < D; i++) begin
      settle();
      chk("init_ready_low", {31'b0, ready}, 32'h0);
      check_all();
      tick();
    end
    settle();
    chk("init_ready_high", {31'b0, ready}, 32'h1);
    for (int a = 0; a < D / NR; a++) begin
      for (int r = 0; r < NR; r++) raddr[r] = 6'(NR * a + r);
      settle();
      for (int r = 0; r < NR; r++) chk("init_zero", rdata[r], 32'h0);
      check_all();
      tick();
    end

    // Directed vectors: byte enables, priority, bypass, zero register.
    for (int i = 0; i < 9; i++) begin
      we[0] = vt[i].we0; waddr[0] = vt[i].wa0; wdata[0] = vt[i].wd0;
      we[1] = vt[i].we1; waddr[1] = vt[i].wa1; wdata[1] = vt[i].wd1;
      raddr = '{6'd9, 6'd7, 6'd5, vt[i].ra};
      settle();
      chk($sformatf("vec%0d_byp", i), rdata[0], vt[i].exp_byp);
      chk($sformatf("vec%0d_nb", i), rdata_nb[0], vt[i].exp_nb);
      chk($sformatf("vec%0d_conf", i), {31'b0, wr_conflict}, {31'b0, vt[i].exp_conf});
      check_all();
      tick();
    end

    // Clear request: fill entries, then pulse clear with a write to entry 3.
    idle_inputs();
    for (int i = 1; i < 12; i++) begin
      we = '{4'hF, 4'hF}; waddr = '{6'(i + 20), 6'(i)}; wdata = '{$urandom | 1, $urandom | 1};
      raddr = '{6'(i + 20), 6'(i), 6'd5, 6'd3};
      step();
    end
    we = '{4'h0, 4'hF}; waddr = '{6'd0, 6'd3}; wdata = '{32'h0, 32'hCAFE0003};
    clear_req = 1'b1; raddr = '{6'd5, 6'd7, 6'd3, 6'd3};
    settle();
    chk("clr_cycle_bypass", rdata[0], 32'hCAFE0003);
    check_all();
    tick();
    for (int i = 0; i < D; i++) begin
      we = '{4'hF, 4'hF}; waddr = '{6'($urandom_range(1, 63)), 6'd3};
      wdata = '{$urandom | 1, $urandom | 1};
      clear_req = (i == 10 || i == 62);
      raddr = '{6'd3, 6'd5, 6'd7, 6'd9};
      settle();
      chk("clr_ready_low", {31'b0, ready}, 32'h0);
      chk("clr_rdata_zero", rdata[0], 32'h0);
      check_all();
      tick();
    end
    idle_inputs();
    settle();
    chk("clr_ready_high", {31'b0, ready}, 32'h1);
    for (int a = 0; a < D / NR; a++) begin
      for (int r = 0; r < NR; r++) raddr[r] = 6'(NR * a + r);
      settle();
      for (int r = 0; r < NR; r++) chk("clr_zero", rdata_nb[r], 32'h0);
      check_all();
      tick();
    end

    // Reset in the middle of a clear restarts the full count.
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    for (int i = 0; i < 20; i++) step();
    rst = 1'b1;
    m_reset();
    step();
    rst = 1'b0;
    for (int i = 0; i < D; i++) begin
      settle();
      chk("rst_mid_ready_low", {31'b0, ready}, 32'h0);
      check_all();
      tick();
    end
    settle();
    chk("rst_mid_ready_high", {31'b0, ready}, 32'h1);
    tick();

    // Randomised traffic against the model; narrow addresses provoke overlap.
    for (int i = 0; i < 3000; i++) begin
      for (int p = 0; p < NW; p++) begin
        we[p]    = 4'($urandom);
        waddr[p] = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
        wdata[p] = $urandom;
      end
      for (int r = 0; r < NR; r++)
        raddr[r] = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
      clear_req = ($urandom_range(0, 299) == 0);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 999) == 0) begin
        rst = 1'b1;
        m_reset();
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
